uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single UART transmitter in `uartprotocoltop` among `N_REQ` independent byte producers. It accepts one byte per grant, drives the transmitter's `tx_data`/`tx_start`, and waits for `tx_done`. It then returns a completion pulse to the owning requester. A watchdog aborts a frame whose `tx_done` never arrives.

---
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ
// byte producers. One byte is accepted per grant, held on tx_data/tx_start
// until the transmitter reports tx_done, then the owner gets a done pulse.
// A saturating watchdog aborts a frame whose tx_done never arrives.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_done
);

  localparam int IDW = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [WDW-1:0] wd;

  logic [7:0]     bytes [N_REQ];
  logic [IDW-1:0] cand;
  logic [IDW-1:0] winner;
  logic           win_valid;
  logic [7:0]     win_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign bytes[i] = req_data[8*i +: 8];
  end

  assign busy = (state != S_IDLE);

  // Round-robin search starting one past the last owner, wrapping through it.
  always_comb begin
    cand      = '0;
    winner    = ptr;
    win_valid = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % N_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
    win_data = bytes[winner];
  end

  // Sequencer: grant in IDLE, hold the frame in WAIT, force one idle cycle in GAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= IDW'(N_REQ - 1);
      wd       <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      grant_id <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            gnt      <= N_REQ'(1) << winner;
            tx_data  <= win_data;
            tx_start <= 1'b1;
            grant_id <= winner;
            ptr      <= winner;
            wd       <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (tx_done) begin
            tx_start <= 1'b0;
            done     <= N_REQ'(1) << grant_id;
            state    <= S_GAP;
          end else if (wd == WD_LAST) begin
            tx_start <= 1'b0;
            err      <= 1'b1;
            state    <= S_GAP;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: cycle table for arbitration order and
// pulse shapes, plus hand sequences for long frames, watchdog and reset.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(50)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .grant_id (grant_id),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       tx_done;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       err;
    logic       ts;
    logic [7:0] data;
    logic       busy;
    logic [1:0] gid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {11'b0, gnt, done, err, tx_start, tx_data, busy, grant_id};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        seen;
    logic        saw_done;
    logic        saw_err;
    logic        ts_at;
    logic        busy_at;
    int          err_at;

    rst      = 1'b1;
    req      = 4'b0000;
    tx_done  = 1'b0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    #2 rst = 1'b0;
    #1 check("reset_async", obs(), 32'h0);
    repeat (2) step();
    check("reset_held", obs(), 32'h0);
    @(negedge clk) rst = 1'b1;

    //        req     tdn   gnt      done     err   ts    data   busy  gid
    vecs.push_back('{4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'h10, 1'b1, 2'd0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'h10, 1'b1, 2'd0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 1'b0, 2'd0});
    vecs.push_back('{4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'h11, 1'b1, 2'd1});
    vecs.push_back('{4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h11, 1'b0, 2'd1});
    vecs.push_back('{4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h12, 1'b1, 2'd2});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'h12, 1'b1, 2'd2});
    vecs.push_back('{4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h12, 1'b0, 2'd2});
    vecs.push_back('{4'b1111, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 8'h13, 1'b1, 2'd3});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'h13, 1'b1, 2'd3});
    vecs.push_back('{4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h13, 1'b0, 2'd3});
    vecs.push_back('{4'b0101, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'h10, 1'b1, 2'd0});
    vecs.push_back('{4'b0101, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'h10, 1'b1, 2'd0});
    vecs.push_back('{4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 1'b0, 2'd0});
    vecs.push_back('{4'b0101, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h12, 1'b1, 2'd2});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'h12, 1'b1, 2'd2});
    vecs.push_back('{4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h12, 1'b0, 2'd2});
    vecs.push_back('{4'b0101, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'h10, 1'b1, 2'd0});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'h10, 1'b1, 2'd0});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 1'b0, 2'd0});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 1'b0, 2'd0});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 1'b0, 2'd0});

    foreach (vecs[i]) begin
      req     = vecs[i].req;
      tx_done = vecs[i].tx_done;
      step();
      check($sformatf("vec%0d", i), obs(),
            {11'b0, vecs[i].gnt, vecs[i].done, vecs[i].err, vecs[i].ts,
             vecs[i].data, vecs[i].busy, vecs[i].gid});
    end
    tx_done = 1'b0;

    // Single request with a 20-cycle frame.
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    step();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_data", 32'({tx_start, tx_data}), 32'h1A5);
    req = 4'b0000;
    saw_err = 1'b0;
    seen    = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (!tx_start || tx_data !== 8'hA5) seen = 1'b1;
      if (err || done != 4'b0) saw_err = 1'b1;
    end
    check("single_hold", 32'(seen), 32'h0);
    check("single_quiet", 32'(saw_err), 32'h0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("single_done", 32'({done, tx_start, busy}), 32'({4'b0001, 1'b0, 1'b1}));
    step();
    check("single_idle", 32'({done, busy}), 32'h0);

    // Watchdog abort.
    req = 4'b0010;
    step();
    check("wd_gnt", 32'(gnt), 32'h2);
    req      = 4'b0000;
    seen     = 1'b0;
    saw_done = 1'b0;
    err_at   = -1;
    ts_at    = 1'b1;
    busy_at  = 1'b0;
    for (int j = 1; j <= 60 && !seen; j++) begin
      step();
      if (done != 4'b0) saw_done = 1'b1;
      if (err) begin
        seen    = 1'b1;
        err_at  = j;
        ts_at   = tx_start;
        busy_at = busy;
      end
    end
    check("wd_err_cycle", 32'(err_at), 32'd50);
    check("wd_no_done", 32'(saw_done), 32'h0);
    check("wd_err_state", 32'({ts_at, busy_at}), 32'b01);
    step();
    check("wd_back_idle", 32'({err, busy}), 32'h0);

    // Completion in the same cycle the watchdog would fire.
    req = 4'b0100;
    step();
    check("race_gnt", 32'(gnt), 32'h4);
    req     = 4'b0000;
    saw_err = 1'b0;
    for (int j = 1; j <= 49; j++) begin
      step();
      if (err || done != 4'b0) saw_err = 1'b1;
    end
    check("race_quiet", 32'(saw_err), 32'h0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("race_done", 32'({done, err}), 32'({4'b0100, 1'b0}));
    step();
    check("race_after", 32'({err, busy}), 32'h0);

    // Reset in the middle of a frame.
    req = 4'b0001;
    step();
    check("rst_pre_gnt", 32'({gnt, grant_id}), 32'({4'b0001, 2'd0}));
    req = 4'b0000;
    repeat (10) step();
    check("rst_pre_ts", 32'(tx_start), 32'h1);
    #2 rst = 1'b0;
    #1 check("rst_mid", 32'({tx_start, busy, grant_id, gnt, done, err}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1000;
    step();
    check("rst_regrant", 32'({gnt, grant_id, tx_start, tx_data}),
          32'({4'b1000, 2'd3, 1'b1, 8'h13}));
    req     = 4'b0000;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("rst_done", 32'({done, err}), 32'({4'b1000, 1'b0}));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
